fcs32_arb: RTL and testbench
============================

# fcs32_arb

Two-requester scheduler that shares one bit-serial FCS32 engine (fcs32_1 per bit, fcs32_brev on completion) between two byte-stream frame sources. It arbitrates round-robin, serialises each granted byte LSB-first into the engine at one bit per bclk_i, and reports the finished FCS tagged with the owning requester. It sits between the frame sources and the FCS compare/append logic.

## Interface
- CRC_INIT, 32'hFFFFFFFF, engine state loaded on sof byte
- bclk_i  in  1  clock; all state on rising edge
- brst_n_i  in  1  reset; synchronous, active-low
- rq0_dat_i / rq1_dat_i  in  8  requester byte
- rq0_sof_i / rq1_sof_i  in  1  byte is first of frame
- rq0_eof_i / rq1_eof_i  in  1  byte is last of frame (sof&eof legal)
- rq0_val_i / rq1_val_i  in  1  byte valid
- rq0_rdy_o / rq1_rdy_o  out  1  byte accepted when val&rdy
- fcs_o  out  32  fcs32_brev of final engine state
- fcs_id_o  out  1  requester owning fcs_o
- fcs_val_o  out  1  one-cycle result strobe
- err_o  out  1  one-cycle protocol-error strobe
- busy_o  out  1  engine shifting

## Operation
- States: IDLE, SHIFT, LOAD (frame-locked mode).
- IDLE: candidates = requesters with val high. Both high -> winner = rr pointer; one high -> that one. Winner's rdy_o high combinationally; other rdy_o low. On accept: byte latched, owner set, SHIFT entered.
- First byte without sof: consumed, discarded, err_o pulses, stay IDLE.
- SHIFT: 8 cycles, bit k (LSB first) -> crc = fcs32_1(bit, crc); on bit 0 of a sof byte the current state is CRC_INIT instead of crc.
- After bit 7: eof byte -> fcs_o = fcs32_brev(crc), fcs_id_o = owner, fcs_val_o pulse, rr pointer = !owner, go IDLE; else -> LOAD.
- LOAD: only owner's rdy_o high. Accepted byte with sof (no eof seen): previous frame abandoned, no result, err_o pulses, crc restarts at CRC_INIT. Go SHIFT.
- rdy_o never high in SHIFT. Non-owner held off for the whole frame.
- fcs_o/fcs_id_o hold until the next result.

## Timing
- Reset: state IDLE, rr pointer 0, crc CRC_INIT, fcs_o 0, fcs_id_o 0, fcs_val_o 0, err_o 0, busy_o 0, both rdy_o 0 during reset.
- Accept on edge E0; bits shifted on E1..E8; fcs_val_o high in the cycle after E8; next rdy_o high in that same cycle.
- Throughput: 1 byte per 9 cycles; N-byte frame result 9N cycles after first accept.
- busy_o high cycles after E0 through E8.
- Reset asserted mid-frame: frame dropped, no fcs_val_o, all outputs to reset values next edge.

## Configuration
- FCS32_ARB_ILV_EN defined: two crc registers (one per requester); re-arbitrate round-robin every byte (from IDLE/LOAD, both requesters eligible); in-frame state per requester tracked; fcs_id_o identifies whose frame ended; sof-without-prior-eof error per requester.
- Undefined: single crc register, frame-locked behaviour above.

## Test plan
- rq0 sends "123456789" (0x31..0x39, sof on first, eof on last), rq1 idle -> fcs_val_o once, fcs_o = 32'hCBF43926, fcs_id_o 0, 81 cycles after first accept.
- Both val high from reset with identical frames -> rq0 served first, then rq1; two results, both 32'hCBF43926, ids 0 then 1; rq1_rdy_o never high during rq0 frame.
- Single byte 0x00 with sof&eof on rq1 -> fcs_o = 32'hD202EF8D, id 1, 9 cycles latency.
- rq0 byte without sof in IDLE -> err_o pulse, no fcs_val_o, rdy back next cycle; mid-frame sof -> err_o, only restarted frame's FCS reported.
- brst_n_i low at bit 4 of byte 3 -> all outputs reset next edge, no result; following frame correct.
- FCS32_ARB_ILV_EN defined, both sending "123456789" concurrently -> bytes alternate 0,1,0,1; both results 32'hCBF43926.

Source files
------------

// File: rtl/fcs32_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fcs32_arb_if : requester byte streams and FCS result bundle for fcs32_arb |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
interface fcs32_arb_if;
  logic [7:0]  rq0_dat_i;
  logic        rq0_sof_i;
  logic        rq0_eof_i;
  logic        rq0_val_i;
  logic        rq0_rdy_o;
  logic [7:0]  rq1_dat_i;
  logic        rq1_sof_i;
  logic        rq1_eof_i;
  logic        rq1_val_i;
  logic        rq1_rdy_o;
  logic [31:0] fcs_o;
  logic        fcs_id_o;
  logic        fcs_val_o;
  logic        err_o;
  logic        busy_o;

  modport slave (
    input  rq0_dat_i, rq0_sof_i, rq0_eof_i, rq0_val_i,
    input  rq1_dat_i, rq1_sof_i, rq1_eof_i, rq1_val_i,
    output rq0_rdy_o, rq1_rdy_o,
    output fcs_o, fcs_id_o, fcs_val_o, err_o, busy_o
  );

  modport master (
    output rq0_dat_i, rq0_sof_i, rq0_eof_i, rq0_val_i,
    output rq1_dat_i, rq1_sof_i, rq1_eof_i, rq1_val_i,
    input  rq0_rdy_o, rq1_rdy_o,
    input  fcs_o, fcs_id_o, fcs_val_o, err_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/fcs32_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fcs32_arb : round-robin share of one bit-serial FCS32 engine by two      |
// |             byte-stream requesters. FCS32_ARB_ILV_EN enables per-byte    |
// |             interleaving with one crc register per requester.            |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module fcs32_arb (
  input  wire logic  bclk_i,
  input  wire logic  brst_n_i,
  fcs32_arb_if.slave bus
);

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY     = 32'h04C1_1DB7;
`ifdef FCS32_ARB_ILV_EN
  localparam bit ILV_EN = 1'b1;
`else
  localparam bit ILV_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
  } state_e;

  function automatic logic [31:0] fcs32_1(input logic b, input logic [31:0] c);
    fcs32_1 = {c[30:0], 1'b0} ^ ((b ^ c[31]) ? POLY : 32'h0);
  endfunction

  // Engine runs MSB-feedback on LSB-first data; bit-reverse plus invert gives the wire FCS.
  function automatic logic [31:0] fcs32_brev(input logic [31:0] c);
    for (int i = 0; i < 32; i++) fcs32_brev[i] = ~c[31-i];
  endfunction

  state_e      state_q, state_d;
  logic        own_q, rr_q, sof_q, eof_q;
  logic [7:0]  sh_q;
  logic [2:0]  cnt_q;
  logic [1:0]  infrm_q;
  logic [31:0] crc0_q, fcs_q;
  logic        fcs_id_q, fcs_val_q, err_q;

  logic        w_c0, w_c1, w_gnt, w_arb, w_acc, w_sof, w_eof, w_bad, w_restart, w_last;
  logic [7:0]  w_dat;
  logic [31:0] w_crc_sel, w_crc_cur, w_crc_nxt;

  always_comb begin
    w_c0 = bus.rq0_val_i;
    w_c1 = bus.rq1_val_i;
    // Frame-locked: only the owner may continue its frame.
    if (!ILV_EN && state_q == S_LOAD) begin
      w_c0 = bus.rq0_val_i & ~own_q;
      w_c1 = bus.rq1_val_i & own_q;
    end
    w_arb         = brst_n_i & (state_q != S_SHIFT);
    w_gnt         = (w_c0 & w_c1) ? rr_q : w_c1;
    bus.rq0_rdy_o = w_arb & w_c0 & ~w_gnt;
    bus.rq1_rdy_o = w_arb & w_c1 & w_gnt;
    w_acc         = bus.rq0_rdy_o | bus.rq1_rdy_o;
    w_dat         = w_gnt ? bus.rq1_dat_i : bus.rq0_dat_i;
    w_sof         = w_gnt ? bus.rq1_sof_i : bus.rq0_sof_i;
    w_eof         = w_gnt ? bus.rq1_eof_i : bus.rq0_eof_i;
    w_bad         = w_acc & ~w_sof & ~infrm_q[w_gnt];
    w_restart     = w_acc & w_sof & infrm_q[w_gnt];
    w_last        = (cnt_q == 3'd7);
    w_crc_cur     = (sof_q && cnt_q == 3'd0) ? CRC_INIT : w_crc_sel;
    w_crc_nxt     = fcs32_1(sh_q[0], w_crc_cur);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_LOAD: if (w_acc && !w_bad) state_d = S_SHIFT;
      S_SHIFT:        if (w_last) state_d = eof_q ? S_IDLE : S_LOAD;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge bclk_i) begin
    if (!brst_n_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge bclk_i) begin
    if (!brst_n_i) begin
      own_q     <= 1'b0;
      rr_q      <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      sh_q      <= 8'h00;
      cnt_q     <= 3'd0;
      infrm_q   <= 2'b00;
      crc0_q    <= CRC_INIT;
      fcs_q     <= 32'h0;
      fcs_id_q  <= 1'b0;
      fcs_val_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      fcs_val_q <= 1'b0;
      err_q     <= w_bad | w_restart;
      if (w_acc && !w_bad) begin
        own_q          <= w_gnt;
        sh_q           <= w_dat;
        sof_q          <= w_sof;
        eof_q          <= w_eof;
        cnt_q          <= 3'd0;
        infrm_q[w_gnt] <= 1'b1;
      end
      if (state_q == S_SHIFT) begin
        sh_q  <= sh_q >> 1;
        cnt_q <= cnt_q + 3'd1;
        if (!(ILV_EN && own_q)) crc0_q <= w_crc_nxt;
        if (w_last) begin
          if (ILV_EN || eof_q) rr_q <= ~own_q;
          if (eof_q) begin
            fcs_q          <= fcs32_brev(w_crc_nxt);
            fcs_id_q       <= own_q;
            fcs_val_q      <= 1'b1;
            infrm_q[own_q] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef FCS32_ARB_ILV_EN
  logic [31:0] crc1_q;

  always_ff @(posedge bclk_i) begin
    if (!brst_n_i)                       crc1_q <= CRC_INIT;
    else if (state_q == S_SHIFT && own_q) crc1_q <= w_crc_nxt;
  end

  assign w_crc_sel = own_q ? crc1_q : crc0_q;
`else
  assign w_crc_sel = crc0_q;
`endif

  assign bus.fcs_o     = fcs_q;
  assign bus.fcs_id_o  = fcs_id_q;
  assign bus.fcs_val_o = fcs_val_q;
  assign bus.err_o     = err_q;
  assign bus.busy_o    = (state_q == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_fcs32_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fcs32_arb : directed self-checking bench for fcs32_arb                |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_fcs32_arb;

  logic bclk   = 1'b0;
  logic brst_n = 1'b0;

  fcs32_arb_if bus();

  fcs32_arb dut (
    .bclk_i   (bclk),
    .brst_n_i (brst_n),
    .bus      (bus)
  );

  always #5 bclk = ~bclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int res_n = 0;
  int err_n = 0;
  int r1_leak = 0;
  int ord_n = 0;
  bit r0_active = 1'b0;
  logic [31:0] res_fcs [8];
  logic        res_id  [8];
  int          res_cyc [8];
  int          sof_acc [2];
  int          ord     [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge bclk) cyc <= cyc + 1;

  always @(negedge bclk) begin
    if (bus.fcs_val_o === 1'b1) begin
      if (res_n < 8) begin
        res_fcs[res_n] = bus.fcs_o;
        res_id[res_n]  = bus.fcs_id_o;
        res_cyc[res_n] = cyc;
      end
      res_n++;
    end
    if (bus.err_o === 1'b1) err_n++;
    if (r0_active && bus.rq1_rdy_o === 1'b1) r1_leak++;
  end

  task automatic drive(input bit r, input logic [7:0] d, input bit s, input bit e, input bit v);
    if (r) begin
      bus.rq1_dat_i = d; bus.rq1_sof_i = s; bus.rq1_eof_i = e; bus.rq1_val_i = v;
    end else begin
      bus.rq0_dat_i = d; bus.rq0_sof_i = s; bus.rq0_eof_i = e; bus.rq0_val_i = v;
    end
  endtask

  function automatic logic rdy(input bit r);
    return r ? bus.rq1_rdy_o : bus.rq0_rdy_o;
  endfunction

  task automatic send_byte(input bit r, input logic [7:0] d, input bit s, input bit e);
    int n = 0;
    @(negedge bclk);
    drive(r, d, s, e, 1'b1);
    #1;
    while (rdy(r) !== 1'b1 && n < 300) begin
      @(negedge bclk);
      #1;
      n++;
    end
    chk("rdy_wait", {31'd0, n < 300}, 32'd1);
    if (n < 300) @(posedge bclk);
    #1;
    if (s) sof_acc[r] = cyc;
    if (ord_n < 32) ord[ord_n] = r;
    ord_n++;
    drive(r, d, s, e, 1'b0);
  endtask

  task automatic send_frame(input bit r);
    for (int i = 0; i < 9; i++) send_byte(r, 8'(8'h31 + i), i == 0, i == 8);
  endtask

  task automatic wait_res(input int n);
    int k = 0;
    while (res_n < n && k < 400) begin
      @(negedge bclk);
      k++;
    end
    chk("res_wait", {31'd0, res_n >= n}, 32'd1);
    repeat (12) @(negedge bclk);
  endtask

  task automatic release_rst;
    @(negedge bclk);
    #2;
    chk("rdy0_in_rst", bus.rq0_rdy_o, 1'b0);
    chk("rdy1_in_rst", bus.rq1_rdy_o, 1'b0);
    @(negedge bclk);
    brst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge bclk);
    #1;
    chk("rst_fcs",   bus.fcs_o, 32'h0);
    chk("rst_id",    bus.fcs_id_o, 1'b0);
    chk("rst_val",   bus.fcs_val_o, 1'b0);
    chk("rst_err",   bus.err_o, 1'b0);
    chk("rst_busy",  bus.busy_o, 1'b0);

`ifdef FCS32_ARB_ILV_EN
    fork
      send_frame(1'b0);
      send_frame(1'b1);
      release_rst();
    join
    wait_res(2);
    for (int i = 0; i < 18; i++) chk($sformatf("ilv_ord%0d", i), ord[i], i % 2);
    chk("ilv_fcs0", res_fcs[0], 32'hCBF43926);
    chk("ilv_id0",  res_id[0], 1'b0);
    chk("ilv_fcs1", res_fcs[1], 32'hCBF43926);
    chk("ilv_id1",  res_id[1], 1'b1);
    chk("ilv_nres", res_n, 2);
`else
    // Both requesters present identical frames straight out of reset.
    fork
      begin
        r0_active = 1'b1;
        send_frame(1'b0);
        r0_active = 1'b0;
      end
      send_frame(1'b1);
      release_rst();
    join
    wait_res(2);
    chk("both_fcs0", res_fcs[0], 32'hCBF43926);
    chk("both_id0",  res_id[0], 1'b0);
    chk("both_fcs1", res_fcs[1], 32'hCBF43926);
    chk("both_id1",  res_id[1], 1'b1);
    chk("both_nres", res_n, 2);
    chk("rq1_held",  r1_leak, 0);
    chk("lat_9byte", res_cyc[0] - sof_acc[0] + 1, 81);

    // Single zero byte, sof and eof together, on rq1.
    res_n = 0;
    send_byte(1'b1, 8'h00, 1'b1, 1'b1);
    chk("busy_shift", bus.busy_o, 1'b1);
    wait_res(1);
    chk("one_fcs",  res_fcs[0], 32'hD202EF8D);
    chk("one_id",   res_id[0], 1'b1);
    chk("one_lat",  res_cyc[0] - sof_acc[1] + 1, 9);
    chk("one_nres", res_n, 1);
    chk("one_idle", bus.busy_o, 1'b0);
    chk("fcs_hold", bus.fcs_o, 32'hD202EF8D);

    // Byte without sof in IDLE, then a frame abandoned by a mid-frame sof.
    res_n = 0;
    err_n = 0;
    send_byte(1'b0, 8'hAA, 1'b0, 1'b0);
    @(negedge bclk);
    #1;
    chk("nosof_err",  bus.err_o, 1'b1);
    chk("nosof_idle", bus.busy_o, 1'b0);
    drive(1'b0, 8'h31, 1'b1, 1'b0, 1'b1);
    #1;
    chk("rdy_back", bus.rq0_rdy_o, 1'b1);
    drive(1'b0, 8'h31, 1'b1, 1'b0, 1'b0);
    send_byte(1'b0, 8'h31, 1'b1, 1'b0);
    send_byte(1'b0, 8'h32, 1'b0, 1'b0);
    send_byte(1'b0, 8'h33, 1'b0, 1'b0);
    send_frame(1'b0);
    wait_res(1);
    chk("restart_errs", err_n, 2);
    chk("restart_nres", res_n, 1);
    chk("restart_fcs",  res_fcs[0], 32'hCBF43926);

    // Reset landing on bit 4 of byte 3 drops the frame.
    res_n = 0;
    send_byte(1'b0, 8'h31, 1'b1, 1'b0);
    send_byte(1'b0, 8'h32, 1'b0, 1'b0);
    send_byte(1'b0, 8'h33, 1'b0, 1'b0);
    repeat (4) @(negedge bclk);
    chk("pre_rst_busy", bus.busy_o, 1'b1);
    brst_n = 1'b0;
    @(negedge bclk);
    #1;
    chk("mid_rst_fcs",  bus.fcs_o, 32'h0);
    chk("mid_rst_id",   bus.fcs_id_o, 1'b0);
    chk("mid_rst_val",  bus.fcs_val_o, 1'b0);
    chk("mid_rst_busy", bus.busy_o, 1'b0);
    @(negedge bclk);
    brst_n = 1'b1;
    send_frame(1'b0);
    wait_res(1);
    chk("post_rst_nres", res_n, 1);
    chk("post_rst_fcs",  res_fcs[0], 32'hCBF43926);
    chk("post_rst_id",   res_id[0], 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
